// File: rtl/frb_trig_pkg.sv
// Shared definitions for the FRB trigger path: default widths and serializer FSM states.
package frb_trig_pkg;

    localparam int unsigned DEF_DIN_WIDTH = 32;
    localparam int unsigned DEF_TS_WIDTH  = 32;
    localparam int unsigned DEF_CNT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/priority_encoder.sv
// Binary index of the lowest set bit of din; 0 when din is zero.
module priority_encoder #(
    parameter int unsigned DIN_WIDTH  = 32,
    parameter int unsigned DOUT_WIDTH = $clog2(DIN_WIDTH)
) (
    input  logic [DIN_WIDTH-1:0]  din,
    output logic [DOUT_WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        // Scan downward so the lowest set bit is the last assignment and wins.
        for (int i = DIN_WIDTH - 1; i >= 0; i--) begin
            if (din[i]) begin
                dout = DOUT_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/hit_mask_serializer.sv
// Captures a threshold-hit mask with its timestamp and emits one valid/ready beat per set bit,
// lowest index first, counting masks that arrive while a scan cannot accept them.
module hit_mask_serializer
    import frb_trig_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int unsigned DOUT_WIDTH = $clog2(DIN_WIDTH),
    parameter int unsigned TS_WIDTH   = DEF_TS_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  hit_mask,
    input  logic [TS_WIDTH-1:0]   hit_ts,
    input  logic                  hit_valid,
    output logic                  hit_ready,
    output logic [DIN_WIDTH-1:0]  dout_onehot,
    output logic [DOUT_WIDTH-1:0] dout_index,
    output logic [TS_WIDTH-1:0]   dout_ts,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam logic [DIN_WIDTH-1:0] MASK_ONE = DIN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [DIN_WIDTH-1:0] mask_q, mask_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic                 scan;
    logic [DIN_WIDTH-1:0] lowest;
    logic [DIN_WIDTH-1:0] rest;
    logic                 handshake;
    logic                 mask_nz;
    logic                 capture;
    logic                 drop;

    // Carry/borrow out of the DIN_WIDTH-wide arithmetic is intentionally discarded.
    assign scan   = (state_q == ST_SCAN);
    assign lowest = mask_q & (~mask_q + MASK_ONE);
    assign rest   = mask_q & (mask_q - MASK_ONE);

    assign dout_valid  = scan;
    assign dout_onehot = scan ? lowest : '0;
    assign dout_last   = scan && (rest == '0);
    assign dout_ts     = ts_q;
    assign drop_cnt    = drop_q;

    assign handshake = scan && dout_ready;
    assign hit_ready = !scan || (handshake && dout_last);
    assign mask_nz   = |hit_mask;
    assign capture   = hit_valid && mask_nz && hit_ready;
    assign drop      = hit_valid && mask_nz && !hit_ready;

    // Valid only because dout_onehot is strictly one-hot or zero.
    priority_encoder #(
        .DIN_WIDTH  (DIN_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_penc (
        .din  (dout_onehot),
        .dout (dout_index)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ts_d    = ts_q;
        drop_d  = drop_q;

        if (handshake) begin
            mask_d = rest;
            if (dout_last) begin
                state_d = ST_IDLE;
            end
        end

        // A capture on the last-beat handshake overrides the return to idle.
        if (capture) begin
            mask_d  = hit_mask;
            ts_d    = hit_ts;
            state_d = ST_SCAN;
        end

        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ts_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ts_q    <= ts_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_hit_mask_serializer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and a randomized
// back-pressure run scored against a set-bit-list reference model.
module tb_hit_mask_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] hit_mask, hit_ts, dout_onehot, dout_ts;
    logic        hit_valid, hit_ready, dout_last, dout_valid, dout_ready;
    logic [4:0]  dout_index;
    logic [15:0] drop_cnt;

    // Shared inputs for the 8-bit and 64-bit instances.
    logic        s_valid, s_ready;
    logic [31:0] s_ts;
    logic [7:0]  m8, oh8;
    logic [2:0]  idx8, dc8;
    logic [31:0] ts8;
    logic        last8, v8, hr8;
    logic [63:0] m64, oh64;
    logic [5:0]  idx64;
    logic [31:0] ts64;
    logic [15:0] dc64;
    logic        last64, v64, hr64;

    int tests = 0;
    int fails = 0;

    hit_mask_serializer dut (
        .clk(clk), .rst(rst), .hit_mask(hit_mask), .hit_ts(hit_ts), .hit_valid(hit_valid),
        .hit_ready(hit_ready), .dout_onehot(dout_onehot), .dout_index(dout_index),
        .dout_ts(dout_ts), .dout_last(dout_last), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .drop_cnt(drop_cnt)
    );

    hit_mask_serializer #(.DIN_WIDTH(8), .CNT_WIDTH(3)) dut8 (
        .clk(clk), .rst(rst), .hit_mask(m8), .hit_ts(s_ts), .hit_valid(s_valid),
        .hit_ready(hr8), .dout_onehot(oh8), .dout_index(idx8), .dout_ts(ts8),
        .dout_last(last8), .dout_valid(v8), .dout_ready(s_ready), .drop_cnt(dc8)
    );

    hit_mask_serializer #(.DIN_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .hit_mask(m64), .hit_ts(s_ts), .hit_valid(s_valid),
        .hit_ready(hr64), .dout_onehot(oh64), .dout_index(idx64), .dout_ts(ts64),
        .dout_last(last64), .dout_valid(v64), .dout_ready(s_ready), .drop_cnt(dc64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        hv;
        logic [31:0] mask;
        logic [31:0] ts;
        logic        rdy;
        logic        e_valid;
        int          e_idx;
        logic        e_last;
        logic        e_hready;
        logic [31:0] e_ts;
        int          e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic hv, input logic [31:0] mask, input logic [31:0] ts,
                                input logic rdy, input logic ev, input int ei, input logic el,
                                input logic eh, input logic [31:0] ets, input int ed);
        vec_t v;
        v.hv = hv; v.mask = mask; v.ts = ts; v.rdy = rdy;
        v.e_valid = ev; v.e_idx = ei; v.e_last = el; v.e_hready = eh; v.e_ts = ets;
        v.e_drop = ed;
        return v;
    endfunction

    // Reference model: each captured mask becomes the ascending list of its set-bit indices.
    typedef struct {
        int          idx;
        logic [31:0] ts;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    exp_drop;

    task automatic mcycle(input logic hv, input logic [31:0] m, input logic [31:0] ts,
                          input logic rdy);
        logic        busy, acc, pred_ready;
        logic [31:0] oh;
        int          n, k;
        beat_t       b;
        hit_valid  = hv;
        hit_mask   = m;
        hit_ts     = ts;
        dout_ready = rdy;
        #1;
        busy       = (exp_q.size() > 0);
        acc        = busy && rdy;
        pred_ready = !busy || (acc && exp_q.size() == 1);
        check("m hit_ready", hit_ready, pred_ready);
        check("m dout_valid", dout_valid, busy);
        if (busy) begin
            oh = 32'd1 << exp_q[0].idx;
            check("m index", dout_index, exp_q[0].idx);
            check("m onehot", dout_onehot, oh);
            check("m last", dout_last, exp_q[0].last);
            check("m ts", dout_ts, exp_q[0].ts);
        end
        if (acc) void'(exp_q.pop_front());
        if (hv && m != 0) begin
            if (pred_ready) begin
                n = $countones(m);
                k = 0;
                for (int i = 0; i < 32; i++) begin
                    if (m[i]) begin
                        k++;
                        b.idx = i; b.ts = ts; b.last = (k == n);
                        exp_q.push_back(b);
                    end
                end
            end else if (exp_drop < 65535) begin
                exp_drop++;
            end
        end
        step();
        check("m drop_cnt", drop_cnt, exp_drop);
    endtask

    initial begin
        int e8[3];
        int e64[3];
        int r;
        logic [31:0] m;
        e8  = '{0, 4, 7};
        e64 = '{0, 4, 63};

        rst = 1'b1;
        hit_valid = 1'b0; hit_mask = '0; hit_ts = '0; dout_ready = 1'b0;
        s_valid = 1'b0; s_ready = 1'b0; s_ts = '0; m8 = '0; m64 = '0;
        step();
        step();
        check("rst valid", dout_valid, 0);
        check("rst onehot", dout_onehot, 0);
        check("rst index", dout_index, 0);
        check("rst last", dout_last, 0);
        check("rst drop", drop_cnt, 0);
        check("rst hit_ready", hit_ready, 1);
        check("rst valid8", v8, 0);
        check("rst valid64", v64, 0);
        rst = 1'b0;

        // Scenario 1 at DIN_WIDTH=8 and 64.
        s_valid = 1'b1; s_ts = 32'd7; s_ready = 1'b1;
        m8 = 8'h91; m64 = 64'h8000_0000_0000_0011;
        step();
        s_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w8 beat%0d valid", k), v8, 1);
            check($sformatf("w8 beat%0d idx", k), idx8, e8[k]);
            check($sformatf("w8 beat%0d last", k), last8, k == 2);
            check($sformatf("w8 beat%0d ts", k), ts8, 7);
            check($sformatf("w64 beat%0d valid", k), v64, 1);
            check($sformatf("w64 beat%0d idx", k), idx64, e64[k]);
            check($sformatf("w64 beat%0d onehot", k), oh64, 64'd1 << e64[k]);
            check($sformatf("w64 beat%0d last", k), last64, k == 2);
            step();
        end
        check("w8 idle", v8, 0);
        check("w64 idle", v64, 0);

        // Saturation: stall a scan, then offer ten more masks.
        s_valid = 1'b1; s_ready = 1'b0; m8 = 8'hFF; m64 = '1;
        step();
        repeat (10) step();
        s_valid = 1'b0;
        step();
        check("sat drop8", dc8, 7);
        check("sat drop64", dc64, 10);
        check("sat scan held valid", v8, 1);
        check("sat scan held idx", idx8, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // hv mask ts rdy | valid idx last hit_ready ts drop
        vecs.push_back(mk(1, 32'h8000_0011, 7, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 7, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4, 0, 0, 7, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 31, 1, 1, 7, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h5, 9, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 9, 0));
        vecs.push_back(mk(1, 32'h2, 10, 1, 1, 2, 1, 1, 9, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 10, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0011, 3, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 4, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 31, 1, 1, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'hF, 1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h1, 2, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 32'h0, 5, 1, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1));

        foreach (vecs[i]) begin
            hit_valid  = vecs[i].hv;
            hit_mask   = vecs[i].mask;
            hit_ts     = vecs[i].ts;
            dout_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d valid", i), dout_valid, vecs[i].e_valid);
            check($sformatf("vec%0d index", i), dout_index, vecs[i].e_idx);
            check($sformatf("vec%0d onehot", i), dout_onehot,
                  vecs[i].e_valid ? (32'd1 << vecs[i].e_idx) : 32'd0);
            check($sformatf("vec%0d last", i), dout_last, vecs[i].e_last);
            check($sformatf("vec%0d hit_ready", i), hit_ready, vecs[i].e_hready);
            if (vecs[i].e_valid) check($sformatf("vec%0d ts", i), dout_ts, vecs[i].e_ts);
            check($sformatf("vec%0d drop", i), drop_cnt, vecs[i].e_drop);
            step();
        end

        // Scenario 7: reset mid-scan abandons the remaining beats and clears the counter.
        exp_q.delete();
        exp_drop = 1;
        mcycle(1, 32'hFF, 32'h5, 1);
        mcycle(0, 0, 0, 1);
        mcycle(0, 0, 0, 1);
        hit_valid = 1'b0;
        dout_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        check("s7 valid after rst", dout_valid, 0);
        check("s7 drop after rst", drop_cnt, 0);
        mcycle(1, 32'h80, 32'h42, 1);
        check("s7 expected beats", exp_q.size(), 1);
        mcycle(0, 0, 0, 1);
        mcycle(0, 0, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 3);
            if (r == 0) m = '0;
            else if (r == 1) m = $urandom;
            else m = $urandom & $urandom & $urandom;
            mcycle($urandom_range(0, 2) == 0, m, $urandom, $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 40; c++) mcycle(0, 0, 0, 1);
        check("drain outstanding beats", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
